mux_select_arbiter: RTL and testbench
=====================================

# mux_select_arbiter

Two-requester round-robin arbiter that owns the select line of a shared 1-bit 2:1 mux (`Mux1Bit2To1`). It sits in the matrix-multiply datapath in front of any resource reached through such a mux, for example a shared memory port or a write-back path contended by two units. Requesters receive exclusive, registered grants. An idle turnaround cycle separates owners. A hold limit bounds how long one owner can block the other.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles an owner keeps while the other requester is waiting. Legal range 1..16.

- `Clk` in 1: the only clock. All state updates on the rising edge.
- `Reset` in 1: synchronous, active-high. Sampled on the `Clk` rising edge.
- `ReqA` in 1: request from requester A. Level signal, held for the duration of use.
- `ReqB` in 1: request from requester B. Level signal.
- `GntA` out 1: A owns the resource. Registered.
- `GntB` out 1: B owns the resource. Registered.
- `Sel` out 1: drives the mux `sel`. 1 selects `inA` (requester A), 0 selects `inB` (requester B). Registered.
- `Busy` out 1: equals `GntA | GntB`.
- `LastGnt` out 1: round-robin pointer. 1 means A was served most recently, 0 means B.
- `HoldCnt` out 4: contention counter of the current owner.

## Operation
- States:
  - `IDLE`: no owner.
  - `OWN_A`: A owns the resource.
  - `OWN_B`: B owns the resource.
  - `TURN`: one dead cycle after a release.
- Decision rule, applied in `IDLE` and in `TURN` to the requests sampled at the edge:
  - Only `ReqA`: go to `OWN_A`.
  - Only `ReqB`: go to `OWN_B`.
  - Both: grant the one not pointed to by `LastGnt`. `LastGnt=1` grants B; `LastGnt=0` grants A.
  - Neither: go to `IDLE`.
- Entering `OWN_A`:
  - `GntA=1`, `GntB=0`, `Sel=1`, `LastGnt=1`, `HoldCnt=0`.
- Entering `OWN_B`:
  - `GntB=1`, `GntA=0`, `Sel=0`, `LastGnt=0`, `HoldCnt=0`.
- In `OWN_x`, `HoldCnt` behaviour depends on the other requester:
  - Other requester's Req=1: `HoldCnt` increments each cycle.
  - Other requester's Req=0: `HoldCnt` clears to 0, so the contention window restarts.
- Release from `OWN_x` to `TURN` happens when either holds at the edge:
  - The owner's Req=0 (voluntary release), or
  - The other Req=1 and `HoldCnt==HOLD_MAX-1` (forced release).
- In `TURN`:
  - `GntA=GntB=0` and `HoldCnt=0`.
  - `Sel` keeps its last value, so the mux output does not glitch.
  - Exit follows the decision rule.
- In `IDLE`: grants are 0 and `Sel` holds its last value.
- `GntA` and `GntB` are never both 1. A grant never changes owner without passing through `TURN`.
- A request withdrawn before it is granted is dropped silently; no grant is issued for it.
- After a forced release the preempted owner keeps its Req high. The decision rule then selects the other requester via `LastGnt`.
- Reset values: state `IDLE`, `GntA=0`, `GntB=0`, `Sel=0`, `Busy=0`, `LastGnt=0` (A wins the first tie), `HoldCnt=0`.
- Reset mid-operation: `Reset` dominates every other input. All outputs take their reset values after the edge, regardless of the requests.

## Timing
- Grant latency from `IDLE`: Req sampled high at edge N gives the grant high in the cycle after edge N (1 cycle).
- Release to next grant:
  - Owner Req low at edge M puts the arbiter in `TURN` for the cycle after M.
  - The new owner's grant rises after edge M+1.
  - Exactly one grant-free cycle separates owners.
- Under continuous contention, an owner holds its grant for exactly `HOLD_MAX` cycles.
- Worst-case wait from request to grant: `HOLD_MAX+2` cycles.
- `Sel` changes only on entry to `OWN_A` or `OWN_B`, in the same cycle the grant rises.
- `HOLD_MAX=1`: with both requesting, grants alternate A, gap, B, gap, and so on, each grant lasting one cycle.

## Test plan
- Reset, then pulse `ReqA` alone for 3 cycles. Expect:
  - `GntA=1`, `Sel=1`, `Busy=1` for 3 cycles, starting 1 cycle after the first `ReqA` edge.
  - Then `TURN`, then `IDLE`.
  - `LastGnt=1`, `Sel` stays 1.
- Assert `ReqA` and `ReqB` together from reset. Expect A granted first. After A drops, B is granted after exactly one grant-free cycle, with `Sel=0`.
- `HOLD_MAX=8`, both requests held high continuously. Expect:
  - Grants alternate A(8), gap(1), B(8), gap(1).
  - `HoldCnt` counts 0..7 within each grant.
- Owner A holds while B toggles: `ReqB` high 3 cycles, low 1, then high. Expect `HoldCnt` to clear during the low cycle and the forced release to occur 8 cycles after `ReqB` re-rises.
- Assert `Reset` while in `OWN_B` with both Req high. Expect:
  - All outputs at reset values the next cycle.
  - A granted first (`LastGnt=0`) after `Reset` deasserts.
- `ReqB` high for 1 cycle during A's ownership, then low. Expect no B grant and `HoldCnt` back to 0.

Source files
------------

// File: rtl/mux_select_arbiter.sv
// -----------------------------------------------------------------------------
// mux_select_arbiter
//
// Two-requester round-robin arbiter that owns the select line of a shared
// 1-bit 2:1 mux. Grants are exclusive and registered. A dead TURN cycle always
// separates two owners. While the other side is waiting, a hold limit caps how
// long one owner can keep the resource.
//
// Parameters
//   HOLD_MAX : maximum consecutive grant cycles under contention (1..16)
//
// Ports
//   Clk      in   rising-edge clock
//   Reset    in   synchronous, active-high; every output returns to its reset
//                 value
//   ReqA     in   level request from requester A
//   ReqB     in   level request from requester B
//   GntA     out  A owns the resource (registered)
//   GntB     out  B owns the resource (registered)
//   Sel      out  mux select: 1 = requester A input, 0 = requester B input
//   Busy     out  GntA | GntB
//   LastGnt  out  round-robin pointer: 1 = A served most recently, 0 = B
//   HoldCnt  out  contention counter of the current owner
// -----------------------------------------------------------------------------
module mux_select_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ReqA,
    input  logic       ReqB,
    output logic       GntA,
    output logic       GntB,
    output logic       Sel,
    output logic       Busy,
    output logic       LastGnt,
    output logic [3:0] HoldCnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TURN  = 2'd3
    } state_t;

    // The counter value seen in the owner's final cycle under contention.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       sel_q,   sel_d;
    logic       last_q,  last_d;
    logic [3:0] hold_q,  hold_d;

    // Decision rule used when nobody owns the resource. On a tie, the side
    // not served most recently wins.
    function automatic state_t decide(input logic req_a,
                                      input logic req_b,
                                      input logic last_was_a);
        if (req_a && (!req_b || !last_was_a)) begin
            return OWN_A;
        end
        if (req_b) begin
            return OWN_B;
        end
        return IDLE;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, TURN: begin
                state_d = decide(ReqA, ReqB, last_q);
            end
            OWN_A: begin
                // Voluntary release, or forced release after HOLD_MAX
                // contended cycles.
                if (!ReqA || (ReqB && (hold_q == HOLD_LAST))) begin
                    state_d = TURN;
                end
            end
            OWN_B: begin
                if (!ReqB || (ReqA && (hold_q == HOLD_LAST))) begin
                    state_d = TURN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);

        // Sel and the pointer change only when a new owner takes over.
        // Otherwise they hold, so the mux output does not glitch in TURN or
        // IDLE.
        sel_d  = sel_q;
        last_d = last_q;
        if ((state_d == OWN_A) && (state_q != OWN_A)) begin
            sel_d  = 1'b1;
            last_d = 1'b1;
        end
        if ((state_d == OWN_B) && (state_q != OWN_B)) begin
            sel_d  = 1'b0;
            last_d = 1'b0;
        end

        // The counter advances only while ownership continues and the other
        // side waits. A gap in the other request restarts the window. Every
        // other case, including entry, TURN and IDLE, leaves it at zero.
        // HOLD_LAST forces a release before the counter can wrap.
        hold_d = '0;
        if ((state_q == OWN_A) && (state_d == OWN_A) && ReqB) begin
            hold_d = hold_q + 4'd1;
        end
        if ((state_q == OWN_B) && (state_d == OWN_B) && ReqA) begin
            hold_d = hold_q + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= 1'b0;
            last_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign GntA    = gnt_a_q;
    assign GntB    = gnt_b_q;
    assign Sel     = sel_q;
    assign Busy    = gnt_a_q | gnt_b_q;
    assign LastGnt = last_q;
    assign HoldCnt = hold_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_select_arbiter
//
// Drives two arbiters from the same request lines: one with HOLD_MAX=8 and one
// with HOLD_MAX=1. Both are checked against an ownership-level reference
// model. An arbiter is either free or owned by a side, and it keeps a tenure
// counter. A free arbiter applies the decision rule, which also covers the
// dead cycle that follows a release.
// -----------------------------------------------------------------------------
module tb_mux_select_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       ReqA;
    logic       ReqB;

    logic       ga0, gb0, sel0, busy0, lg0;
    logic [3:0] hc0;
    logic       ga1, gb1, sel1, busy1, lg1;
    logic [3:0] hc1;

    mux_select_arbiter #(.HOLD_MAX(8)) dut0 (
        .Clk(Clk), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB),
        .GntA(ga0), .GntB(gb0), .Sel(sel0), .Busy(busy0),
        .LastGnt(lg0), .HoldCnt(hc0)
    );

    mux_select_arbiter #(.HOLD_MAX(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB),
        .GntA(ga1), .GntB(gb1), .Sel(sel1), .Busy(busy1),
        .LastGnt(lg1), .HoldCnt(hc1)
    );

    always #5 Clk = ~Clk;

    // Observed outputs, packed as {GntA, GntB, Sel, Busy, LastGnt, HoldCnt}.
    logic [8:0] obs [2];
    assign obs[0] = {ga0, gb0, sel0, busy0, lg0, hc0};
    assign obs[1] = {ga1, gb1, sel1, busy1, lg1, hc1};

    // Reference model state: owner 0 = free, 1 = A, 2 = B.
    int hm_m    [2] = '{8, 1};
    int owner_m [2] = '{0, 0};
    bit sel_m   [2] = '{1'b0, 1'b0};
    bit last_m  [2] = '{1'b0, 1'b0};
    int hold_m  [2] = '{0, 0};

    int vectors     = 0;
    int miscompares = 0;

    task automatic model_step(input bit ra, input bit rb, input bit rst);
        for (int k = 0; k < 2; k++) begin
            bit mine;
            bit other;
            if (rst) begin
                owner_m[k] = 0; sel_m[k] = 1'b0; last_m[k] = 1'b0; hold_m[k] = 0;
            end else if (owner_m[k] == 0) begin
                if (ra && (!rb || !last_m[k])) begin
                    owner_m[k] = 1; sel_m[k] = 1'b1; last_m[k] = 1'b1;
                end else if (rb) begin
                    owner_m[k] = 2; sel_m[k] = 1'b0; last_m[k] = 1'b0;
                end
                hold_m[k] = 0;
            end else begin
                mine  = (owner_m[k] == 1) ? ra : rb;
                other = (owner_m[k] == 1) ? rb : ra;
                if (!mine || (other && (hold_m[k] == hm_m[k] - 1))) begin
                    owner_m[k] = 0;
                    hold_m[k]  = 0;
                end else begin
                    hold_m[k] = other ? hold_m[k] + 1 : 0;
                end
            end
        end
    endtask

    function automatic logic [8:0] expv(input int k);
        logic [3:0] h;
        h = 4'(hold_m[k]);
        return {owner_m[k] == 1, owner_m[k] == 2, sel_m[k], owner_m[k] != 0, last_m[k], h};
    endfunction

    // One clock: apply inputs, let the edge happen, advance the model, then
    // settle 1 time unit past the edge before anything is sampled.
    task automatic cycle(input bit ra, input bit rb, input bit rst);
        ReqA  = ra;
        ReqB  = rb;
        Reset = rst;
        @(posedge Clk);
        model_step(ra, rb, rst);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== 9'b0) begin
                    miscompares++;
                    $display("FAIL reset dut%0d step %0d: got %b want %b", k, i, obs[k], 9'b0);
                end
            end
        end
    endtask

    task automatic test_single_a();
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(i < 3, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== expv(k)) begin
                    miscompares++;
                    $display("FAIL single_a dut%0d step %0d: got %b want %b", k, i, obs[k], expv(k));
                end
            end
            vectors++;
            if ({ga0, sel0, busy0} !== ((i < 3) ? 3'b111 : 3'b010)) begin
                miscompares++;
                $display("FAIL single_a_gnt step %0d: got %b want %b", i, {ga0, sel0, busy0},
                         (i < 3) ? 3'b111 : 3'b010);
            end
        end
        vectors++;
        if ({lg0, sel0} !== 2'b11) begin
            miscompares++;
            $display("FAIL single_a_ptr: got %b want 11", {lg0, sel0});
        end
    endtask

    task automatic test_tie_from_reset();
        bit ra_t [5] = '{1, 1, 0, 0, 0};
        bit rb_t [5] = '{1, 1, 1, 1, 0};
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(ra_t[i], rb_t[i], 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== expv(k)) begin
                    miscompares++;
                    $display("FAIL tie dut%0d step %0d: got %b want %b", k, i, obs[k], expv(k));
                end
            end
            if (i == 0) begin
                vectors++;
                if ({ga0, gb0} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL tie_first step %0d: got %b want 10", i, {ga0, gb0});
                end
            end
            if (i == 2) begin
                vectors++;
                if (busy0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL tie_gap: got %b want 0", busy0);
                end
            end
            if (i == 3) begin
                vectors++;
                if ({gb0, sel0} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL tie_b: got %b want 10", {gb0, sel0});
                end
            end
        end
    endtask

    task automatic test_contention();
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== expv(k)) begin
                    miscompares++;
                    $display("FAIL contention dut%0d step %0d: got %b want %b", k, i, obs[k], expv(k));
                end
            end
            // A owns steps 0..7, step 8 is the gap, B owns 9..16, and the
            // pattern repeats every 18 steps.
            begin
                int ph;
                logic [1:0] want;
                ph   = i % 18;
                want = {ph < 8, (ph >= 9) && (ph < 17)};
                vectors++;
                if ({ga0, gb0} !== want) begin
                    miscompares++;
                    $display("FAIL contention_gnt step %0d: got %b want %b", i, {ga0, gb0}, want);
                end
                if (ph < 8) begin
                    vectors++;
                    if (hc0 !== 4'(ph)) begin
                        miscompares++;
                        $display("FAIL contention_cnt step %0d: got %0d want %0d", i, hc0, ph);
                    end
                end
            end
        end
    endtask

    task automatic test_toggle_b();
        bit rb_t [16] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, rb_t[i], 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== expv(k)) begin
                    miscompares++;
                    $display("FAIL toggle_b dut%0d step %0d: got %b want %b", k, i, obs[k], expv(k));
                end
            end
            if (i == 3) begin
                vectors++;
                if ({ga0, hc0} !== 5'b1_0000) begin
                    miscompares++;
                    $display("FAIL toggle_clear: got %b want 10000", {ga0, hc0});
                end
            end
            if (i == 10 || i == 11) begin
                vectors++;
                if (ga0 !== (i == 10)) begin
                    miscompares++;
                    $display("FAIL toggle_release step %0d: got %b want %b", i, ga0, i == 10);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        vectors++;
        if (gb0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_own_b: got %b want 1", gb0);
        end
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== 9'b0) begin
                miscompares++;
                $display("FAIL reset_mid dut%0d: got %b want %b", k, obs[k], 9'b0);
            end
        end
        cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== expv(k)) begin
                miscompares++;
                $display("FAIL reset_mid_after dut%0d: got %b want %b", k, obs[k], expv(k));
            end
        end
        vectors++;
        if ({ga0, ga1} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_mid_a_first: got %b want 11", {ga0, ga1});
        end
    endtask

    task automatic test_short_b();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, i == 0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== expv(k)) begin
                    miscompares++;
                    $display("FAIL short_b dut%0d step %0d: got %b want %b", k, i, obs[k], expv(k));
                end
            end
            vectors++;
            if ({ga0, gb0, hc0} !== {2'b10, (i == 0) ? 4'd1 : 4'd0}) begin
                miscompares++;
                $display("FAIL short_b_dut0 step %0d: got %b want %b", i, {ga0, gb0, hc0},
                         {2'b10, (i == 0) ? 4'd1 : 4'd0});
            end
        end
    endtask

    task automatic test_random();
        bit ra = 1'b0;
        bit rb = 1'b0;
        bit rst;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) ra = ~ra;
            if ($urandom_range(3) == 0) rb = ~rb;
            rst = ($urandom_range(99) == 0);
            cycle(ra, rb, rst);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== expv(k)) begin
                    miscompares++;
                    $display("FAIL random dut%0d step %0d: got %b want %b", k, i, obs[k], expv(k));
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        ReqA  = 1'b0;
        ReqB  = 1'b0;
        test_reset();
        test_single_a();
        test_tie_from_reset();
        test_contention();
        test_toggle_b();
        test_reset_mid();
        test_short_b();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
